// File: rtl/fifo_alu_sequencer.sv
// Packet sequencer: pulls 5-byte packets (header, A, B) from a byte FIFO,
// issues one ALU operation per packet and holds the result for a ready/valid sink.
module fifo_alu_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  fifo_data_out,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_operation,
  output logic        alu_start,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  input  logic        alu_overflow,
  output logic [15:0] res_data,
  output logic        res_ovf,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        err_hdr,
  output logic        err_timeout,
  output logic [7:0]  pkt_count
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {FETCH, CAPT, ISSUE, WAIT_ALU, OUTPUT} state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_idx;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_a, r_b, r_res;
  logic [2:0]  r_op;
  logic        r_ovf, r_err_hdr, r_err_to;
  logic [7:0]  r_pkt;
  logic        w_hdr_bad, w_timeout;

  assign w_hdr_bad = (r_idx == 3'd0) && (fifo_data_out[7:3] != 5'd0);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    fifo_rd_en = 1'b0;
    alu_start  = 1'b0;
    res_valid  = 1'b0;
    case (r_state)
      FETCH: begin
        // Gated by rst_n so no read strobe escapes while reset is held.
        fifo_rd_en = !fifo_empty && rst_n;
        if (!fifo_empty) w_next = CAPT;
      end
      CAPT:     w_next = (r_idx == 3'd4) ? ISSUE : FETCH;
      ISSUE: begin
        alu_start = 1'b1;
        w_next    = WAIT_ALU;
      end
      WAIT_ALU: if (alu_done || w_timeout) w_next = OUTPUT;
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = FETCH;
      end
      default:  w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= 3'd0;
      r_cnt     <= '0;
      r_a       <= 16'd0;
      r_b       <= 16'd0;
      r_op      <= 3'd0;
      r_res     <= 16'd0;
      r_ovf     <= 1'b0;
      r_err_hdr <= 1'b0;
      r_err_to  <= 1'b0;
      r_pkt     <= 8'd0;
    end else begin
      case (r_state)
        CAPT: begin
          // A bad header is dropped in place so the next byte is tried as a header.
          if (w_hdr_bad) begin
            r_err_hdr <= 1'b1;
          end else begin
            case (r_idx)
              3'd0:    r_op      <= fifo_data_out[2:0];
              3'd1:    r_a[15:8] <= fifo_data_out;
              3'd2:    r_a[7:0]  <= fifo_data_out;
              3'd3:    r_b[15:8] <= fifo_data_out;
              default: r_b[7:0]  <= fifo_data_out;
            endcase
            r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT_ALU: begin
          if (alu_done) begin
            r_res <= alu_result;
            r_ovf <= alu_overflow;
          end else if (w_timeout) begin
            r_err_to <= 1'b1;
            r_res    <= 16'hFFFF;
            r_ovf    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        OUTPUT: if (res_ready) r_pkt <= r_pkt + 8'd1;
        default: ;
      endcase
    end
  end

  assign alu_a         = r_a;
  assign alu_b         = r_b;
  assign alu_operation = r_op;
  assign res_data      = r_res;
  assign res_ovf       = r_ovf;
  assign err_hdr       = r_err_hdr;
  assign err_timeout   = r_err_to;
  assign pkt_count     = r_pkt;

endmodule

// File: tb/tb_fifo_alu_sequencer.sv
// Directed bench: table of packets with hand-computed operands plus sequences for
// header resync, result back-pressure, FIFO underrun, ALU timeout and mid-wait reset.
module tb_fifo_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fifo_data_out = 8'd0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] alu_a, alu_b;
  logic [2:0]  alu_operation;
  logic        alu_start;
  logic [15:0] alu_result = 16'd0;
  logic        alu_done = 1'b0;
  logic        alu_overflow = 1'b0;
  logic [15:0] res_data;
  logic        res_ovf, res_valid;
  logic        res_ready = 1'b1;
  logic        err_hdr, err_timeout;
  logic [7:0]  pkt_count;

  fifo_alu_sequencer #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .alu_start(alu_start),
    .alu_result(alu_result), .alu_done(alu_done), .alu_overflow(alu_overflow),
    .res_data(res_data), .res_ovf(res_ovf), .res_valid(res_valid), .res_ready(res_ready),
    .err_hdr(err_hdr), .err_timeout(err_timeout), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  // Byte FIFO model: data appears the cycle after a granted read.
  logic [7:0] fmem [0:255];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (rp == wp);
  always @(posedge clk) if (fifo_rd_en) begin
    fifo_data_out <= fmem[rp[7:0]];
    rp <= rp + 1;
  end

  int   starts = 0;
  int   rd_viol = 0;
  logic prev_rd = 1'b0;
  always @(posedge clk) begin
    if (alu_start) starts <= starts + 1;
    if (fifo_rd_en && (prev_rd || fifo_empty)) rd_viol <= rd_viol + 1;
    prev_rd <= fifo_rd_en;
  end

  typedef struct {
    logic [39:0] bytes;
    logic [15:0] res;
    logic        ovf;
    logic [15:0] ea, eb;
    logic [2:0]  eop;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int exp_pkt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp[7:0]] = b;
    wp = wp + 1;
  endtask

  task automatic push_pkt(input logic [39:0] p);
    for (int i = 0; i < 5; i++) push(p[39-8*i -: 8]);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (alu_start) begin ok = 1'b1; break; end
    end
    chk("alu_start seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 200; i++) begin
      if (res_valid) begin ok = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    chk("res_valid seen", {31'd0, ok}, 32'd1);
  endtask

  // d = cycles after start at which alu_done pulses; 0 = never.
  task automatic run(input vec_t v, input bit do_push, input int d, output int nwait);
    bit ok;
    int s0;
    nwait = 0;
    if (do_push) push_pkt(v.bytes);
    s0 = starts;
    wait_start(ok);
    if (ok) begin
      chk("alu_a", {16'd0, alu_a}, {16'd0, v.ea});
      chk("alu_b", {16'd0, alu_b}, {16'd0, v.eb});
      chk("alu_operation", {29'd0, alu_operation}, {29'd0, v.eop});
      if (d > 0) begin
        repeat (d) @(negedge clk);
        alu_done = 1'b1; alu_result = v.res; alu_overflow = v.ovf;
        @(negedge clk);
        alu_done = 1'b0; alu_overflow = 1'b0;
      end
      wait_valid(ok, nwait);
      if (ok) begin
        chk("res_data", {16'd0, res_data}, {16'd0, v.res});
        chk("res_ovf", {31'd0, res_ovf}, {31'd0, v.ovf});
        chk("alu_start pulses", starts - s0, 32'd1);
        if (res_ready) begin
          @(negedge clk);
          exp_pkt = (exp_pkt + 1) % 256;
          chk("pkt_count", {24'd0, pkt_count}, exp_pkt);
          chk("res_valid drop", {31'd0, res_valid}, 32'd0);
        end
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " fifo_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
    chk({tag, " alu_start"}, {31'd0, alu_start}, 32'd0);
    chk({tag, " alu_a"}, {16'd0, alu_a}, 32'd0);
    chk({tag, " alu_b"}, {16'd0, alu_b}, 32'd0);
    chk({tag, " alu_operation"}, {29'd0, alu_operation}, 32'd0);
    chk({tag, " res_data"}, {16'd0, res_data}, 32'd0);
    chk({tag, " res_ovf"}, {31'd0, res_ovf}, 32'd0);
    chk({tag, " res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({tag, " err_hdr"}, {31'd0, err_hdr}, 32'd0);
    chk({tag, " err_timeout"}, {31'd0, err_timeout}, 32'd0);
    chk({tag, " pkt_count"}, {24'd0, pkt_count}, 32'd0);
  endtask

  vec_t tbl [5];

  initial begin
    vec_t v;
    int   nw;
    bit   ok;
    int   s0;
    logic [15:0] held;

    tbl[0] = '{40'h01_00_05_00_03, 16'h0008, 1'b0, 16'h0005, 16'h0003, 3'd1};
    tbl[1] = '{40'h02_12_34_00_01, 16'h1235, 1'b0, 16'h1234, 16'h0001, 3'd2};
    tbl[2] = '{40'h07_FF_FF_00_01, 16'h0000, 1'b1, 16'hFFFF, 16'h0001, 3'd7};
    tbl[3] = '{40'h00_80_00_80_00, 16'h0000, 1'b1, 16'h8000, 16'h8000, 3'd0};
    tbl[4] = '{40'h03_A5_5A_0F_F0, 16'h0550, 1'b0, 16'hA55A, 16'h0FF0, 3'd3};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run(tbl[i], 1'b1, 1, nw);

    // Bad header F9 is dropped, following packet decoded normally.
    chk("err_hdr before", {31'd0, err_hdr}, 32'd0);
    push(8'hF9);
    run(tbl[1], 1'b1, 1, nw);
    chk("err_hdr after", {31'd0, err_hdr}, 32'd1);

    // Back-pressure with the next packet already waiting in the FIFO.
    res_ready = 1'b0;
    push_pkt(tbl[0].bytes);
    push_pkt(tbl[4].bytes);
    run(tbl[0], 1'b0, 1, nw);
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      chk("stall res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall res_data", {16'd0, res_data}, {16'd0, held});
      chk("stall fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("stall pkt_count", {24'd0, pkt_count}, exp_pkt);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    exp_pkt++;
    chk("handshake pkt_count", {24'd0, pkt_count}, exp_pkt);
    run(tbl[4], 1'b0, 1, nw);

    // FIFO runs dry after two bytes; no reads while empty, packet resumes intact.
    push(8'h01); push(8'h00);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      chk("underrun fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      @(negedge clk);
    end
    push(8'h05); push(8'h00); push(8'h03);
    run(tbl[0], 1'b0, 1, nw);

    // Done on the final allowed wait cycle wins over timeout.
    v = '{40'h04_00_10_00_20, 16'h0030, 1'b0, 16'h0010, 16'h0020, 3'd4};
    run(v, 1'b1, 64, nw);
    chk("boundary err_timeout", {31'd0, err_timeout}, 32'd0);

    // ALU never answers.
    v = '{40'h05_00_01_00_02, 16'hFFFF, 1'b1, 16'h0001, 16'h0002, 3'd5};
    run(v, 1'b1, 0, nw);
    chk("timeout wait cycles", nw - 1, 32'd64);
    chk("timeout err_timeout", {31'd0, err_timeout}, 32'd1);

    // Reset while waiting on the ALU; late done must be ignored.
    push_pkt(tbl[1].bytes);
    wait_start(ok);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midwait");
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    exp_pkt = 0;
    @(negedge clk);
    alu_done = 1'b1; alu_result = 16'h1234; alu_overflow = 1'b1;
    @(negedge clk);
    alu_done = 1'b0; alu_overflow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post-reset res_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
    end
    chk("post-reset pkt_count", {24'd0, pkt_count}, 32'd0);
    chk("post-reset res_data", {16'd0, res_data}, 32'd0);
    chk("post-reset alu_start", starts - s0, 32'd0);

    chk("fifo_rd_en protocol", rd_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_alu_sequencer.md
FIFO_ALU_SEQUENCER -- requirements
Module: fifo_alu_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles to wait for alu_done after alu_start.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 fifo_data_out  input  8  byte from upstream FIFO, valid the cycle after a granted fifo_rd_en.
REQ-005 fifo_empty  input  1  upstream FIFO empty.
REQ-006 fifo_rd_en  output  1  FIFO read strobe.
REQ-007 alu_a  output  16  ALU operand A.
REQ-008 alu_b  output  16  ALU operand B.
REQ-009 alu_operation  output  3  ALU opcode.
REQ-010 alu_start  output  1  one-cycle ALU start pulse.
REQ-011 alu_result  input  16  ALU result.
REQ-012 alu_done  input  1  ALU result-valid pulse.
REQ-013 alu_overflow  input  1  ALU overflow, qualified by alu_done.
REQ-014 res_data  output  16  captured ALU result.
REQ-015 res_ovf  output  1  captured overflow.
REQ-016 res_valid  output  1  result available downstream.
REQ-017 res_ready  input  1  downstream accepts result.
REQ-018 err_hdr  output  1  sticky: header byte with nonzero reserved bits seen.
REQ-019 err_timeout  output  1  sticky: ALU timeout occurred.
REQ-020 pkt_count  output  8  completed-packet counter.

Function
REQ-021 Packet = 5 FIFO bytes in order: header, A[15:8], A[7:0], B[15:8], B[7:0]; header[2:0] = opcode, header[7:3] reserved (must be 0).
REQ-022 States: FETCH, CAPT, ISSUE, WAIT_ALU, OUTPUT.
REQ-023 FETCH: fifo_rd_en = !fifo_empty (combinational); on granted read go to CAPT; else stay.
REQ-024 CAPT: register fifo_data_out into byte slot selected by 3-bit byte index; index 0..3 -> index+1, return to FETCH; index 4 -> index 0, go to ISSUE.
REQ-025 Header with header[7:3] != 0: byte discarded, index stays 0, err_hdr set, return to FETCH (resync).
REQ-026 fifo_rd_en never asserted outside FETCH; at most one read per two cycles.
REQ-027 ISSUE: alu_start = 1 for exactly one cycle; alu_a/alu_b/alu_operation held stable from ISSUE until leaving WAIT_ALU; go to WAIT_ALU.
REQ-028 WAIT_ALU: on alu_done capture alu_result -> res_data, alu_overflow -> res_ovf, go to OUTPUT; alu_done outside WAIT_ALU ignored.
REQ-029 Timeout counter clears on entry to WAIT_ALU; if TIMEOUT cycles elapse without alu_done: set err_timeout, res_data = 16'hFFFF, res_ovf = 1, go to OUTPUT.
REQ-030 alu_done in the same cycle the counter reaches TIMEOUT: done wins, no error.
REQ-031 OUTPUT: res_valid = 1; res_data/res_ovf stable while res_valid && !res_ready.
REQ-032 res_valid && res_ready: pkt_count increments (wraps 255 -> 0), res_valid drops next cycle, go to FETCH.
REQ-033 Minimum packet latency (FIFO never empty, ALU done 1 cycle after start, res_ready high): 10 cycles FETCH-to-FETCH for fetch plus 3 for issue/wait/output.
REQ-034 Sticky errors clear only on reset.

Reset
REQ-035 On rst_n low (async): state FETCH, byte index 0, fifo_rd_en 0, alu_start 0, alu_a/alu_b 0, alu_operation 0, res_data 0, res_ovf 0, res_valid 0, err_hdr 0, err_timeout 0, pkt_count 0, timeout counter 0.
REQ-036 Reset mid-packet or mid-ALU-wait discards partial packet; alu_done arriving after reset release is ignored (state FETCH).

Verification
REQ-037 Bytes 01,00,05,00,03, ALU returns 0008 -> alu_start once with a=0005, b=0003, op=1; res_data=0008, res_ovf=0, pkt_count=1.
REQ-038 Header F9 then valid packet 02,12,34,00,01 -> err_hdr=1, F9 discarded, ALU issued with op=2, a=1234, b=0001.
REQ-039 Valid packet, ALU never asserts done, TIMEOUT=64 -> 64 cycles in WAIT_ALU, err_timeout=1, res_data=FFFF, res_ovf=1.
REQ-040 Result pending, res_ready low 5 cycles -> res_valid held, res_data stable, no fifo_rd_en, pkt_count increments only on handshake cycle.
REQ-041 fifo_empty toggled after byte 2 for 7 cycles -> fifo_rd_en 0 while empty, packet resumes at byte index 2 with no lost/duplicated byte.
REQ-042 rst_n pulsed low in WAIT_ALU, alu_done after release -> all outputs at reset values, no res_valid, pkt_count 0.
